// File: rtl/dvp_frame_tx.sv
// DVP camera-style frame transmitter: streams a frame buffer of 32-bit words out as
// VSYNC/HREF-framed bytes, reading each word from a synchronous-read RAM just in time.
module dvp_frame_tx #(
    parameter int H_PIXELS  = 160,
    parameter int V_LINES   = 120,
    parameter int VSYNC_CYC = 16,
    parameter int V_BP      = 8,
    parameter int H_BLANK   = 8,
    parameter int V_FP      = 8
) (
    input  logic        i_pclk,
    input  logic        i_hreset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_ram_raddr,
    input  logic [31:0] i_ram_rdata,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_dvp_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int LINE_BYTES = 2 * H_PIXELS;
    localparam int N_WORDS    = H_PIXELS * V_LINES / 2;
    localparam int CNT_MAX    = max2(max2(max2(VSYNC_CYC, V_BP), max2(LINE_BYTES, H_BLANK)), V_FP);
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int LINE_W     = $clog2(V_LINES + 1);

    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VSYNC_CYC - 1);
    localparam logic [CNT_W-1:0]  VBP_LAST  = CNT_W'(V_BP - 1);
    localparam logic [CNT_W-1:0]  LINE_LAST = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  HBL_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]  VFP_LAST  = CNT_W'(V_FP - 1);
    localparam logic [LINE_W-1:0] LINES_ALL = LINE_W'(V_LINES);
    localparam logic [15:0]       ADDR_LAST = 16'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VS   = 3'd1,
        S_VBP  = 3'd2,
        S_LINE = 3'd3,
        S_HBL  = 3'd4,
        S_VFP  = 3'd5
    } state_t;

    // Byte 0 comes straight off the RAM bus; bytes 1..3 from the word captured alongside it.
    function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic [31:0] rd,
                                            input logic [23:0] held);
        logic [7:0] b;
        case (idx)
            2'd0:    b = rd[7:0];
            2'd1:    b = held[7:0];
            2'd2:    b = held[15:8];
            default: b = held[23:16];
        endcase
        return b;
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;
    logic [23:0]       r_word;
    logic [15:0]       r_raddr;
    logic              r_vsync, r_href, r_busy, r_frame_done;
    logic [7:0]        r_dvp_data;

    state_t            w_next_state;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [LINE_W-1:0] w_next_line;
    logic              w_accept;
    logic              w_load;
    logic [7:0]        w_dvp_data;

    // Next-state, per-state cycle counter and line counter.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + CNT_W'(1);
        w_next_line  = r_line;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt  = '0;
                w_next_line = '0;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_VS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_VS: begin
                if (r_cnt == VS_LAST) begin
                    w_next_state = S_VBP;
                    w_next_cnt   = '0;
                end else begin
                    w_next_state = S_VS;
                end
            end
            S_VBP: begin
                if (r_cnt == VBP_LAST) begin
                    w_next_state = S_LINE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_state = S_VBP;
                end
            end
            S_LINE: begin
                if (r_cnt == LINE_LAST) begin
                    w_next_state = S_HBL;
                    w_next_cnt   = '0;
                    w_next_line  = r_line + LINE_W'(1);
                end else begin
                    w_next_state = S_LINE;
                end
            end
            S_HBL: begin
                if (r_cnt == HBL_LAST) begin
                    w_next_state = (r_line == LINES_ALL) ? S_VFP : S_LINE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_state = S_HBL;
                end
            end
            S_VFP: begin
                if (r_cnt == VFP_LAST) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                    w_next_line  = '0;
                end else begin
                    w_next_state = S_VFP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
                w_next_line  = '0;
            end
        endcase
    end

    // A new word is needed whenever the next cycle carries byte 0 of a word.
    always_comb begin
        w_load = (w_next_state == S_LINE) && (w_next_cnt[1:0] == 2'b00);
        if (w_next_state == S_LINE) begin
            w_dvp_data = byte_sel(w_next_cnt[1:0], i_ram_rdata, r_word);
        end else begin
            w_dvp_data = 8'h00;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_pclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_word       <= 24'h000000;
            r_raddr      <= 16'h0000;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_dvp_data   <= 8'h00;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_line       <= w_next_line;
            r_vsync      <= (w_next_state == S_VS);
            r_href       <= (w_next_state == S_LINE);
            r_busy       <= (w_next_state != S_IDLE);
            r_frame_done <= (w_next_state == S_VFP) && (w_next_cnt == VFP_LAST);
            r_dvp_data   <= w_dvp_data;
            r_word       <= w_load ? i_ram_rdata[31:8] : r_word;
            // Advance the address as soon as the current word is captured, so the next
            // word is on the RAM bus well before its first byte; hold on the last word.
            if (w_accept) begin
                r_raddr <= 16'h0000;
            end else if (w_load && (r_raddr != ADDR_LAST)) begin
                r_raddr <= r_raddr + 16'h0001;
            end else begin
                r_raddr <= r_raddr;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_ram_raddr  = r_raddr;
    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_dvp_data   = r_dvp_data;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Self-checking bench for dvp_frame_tx: a small-parameter instance driven by a cycle table
// and corner-case sequences, plus a default-parameter instance run for one full frame.
module tb_dvp_frame_tx;

    logic        clk = 1'b0;
    logic        rst, start, start_d;
    logic        busy, done, vsync, href;
    logic [15:0] raddr;
    logic [31:0] rdata;
    logic [7:0]  data;
    logic        busy_d, done_d, vsync_d, href_d;
    logic [15:0] raddr_d;
    logic [31:0] rdata_d;
    logic [7:0]  data_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dvp_frame_tx #(.H_PIXELS(4), .V_LINES(2), .VSYNC_CYC(3), .V_BP(2), .H_BLANK(2), .V_FP(2)) dut (
        .i_pclk(clk), .i_hreset(rst), .i_start(start), .o_busy(busy), .o_frame_done(done),
        .o_ram_raddr(raddr), .i_ram_rdata(rdata), .o_vsync(vsync), .o_href(href), .o_dvp_data(data)
    );

    dvp_frame_tx dut_def (
        .i_pclk(clk), .i_hreset(rst), .i_start(start_d), .o_busy(busy_d), .o_frame_done(done_d),
        .o_ram_raddr(raddr_d), .i_ram_rdata(rdata_d), .o_vsync(vsync_d), .o_href(href_d),
        .o_dvp_data(data_d)
    );

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return 32'h44332211 + 32'(a) * 32'h01010101;
    endfunction

    // Synchronous-read frame buffers.
    always @(posedge clk) begin
        rdata   <= word_of(raddr);
        rdata_d <= word_of(raddr_d);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Running byte model and address-run log for the small instance.
    int          bcnt = 0;
    logic [15:0] addr_q[$];
    always @(negedge clk) begin
        if (rst || vsync) bcnt = 0;
        if (href) begin
            if (bcnt >= 16) begin
                chk("byte_overrun", 32'(bcnt), 32'd15);
            end else begin
                chk($sformatf("stream_byte%0d", bcnt), 32'(data),
                    (word_of(16'(bcnt / 4)) >> (8 * (bcnt % 4))) & 32'hFF);
            end
            bcnt++;
        end else begin
            chk("data_zero_when_href_low", 32'(data), 32'd0);
        end
        chk("vsync_href_exclusive", 32'(vsync & href), 32'd0);
        if (busy && (addr_q.size() == 0 || raddr != addr_q[$])) addr_q.push_back(raddr);
    end

    typedef struct {
        logic       start;
        logic       vs;
        logic       hr;
        logic [7:0] d;
        logic       bz;
        logic       fd;
    } vec_t;
    vec_t tbl[29];

    task automatic run_table(input string tag);
        for (int i = 0; i < 29; i++) begin
            start = tbl[i].start;
            @(negedge clk);
            chk($sformatf("%s_vsync[%0d]", tag, i), 32'(vsync), 32'(tbl[i].vs));
            chk($sformatf("%s_href[%0d]", tag, i), 32'(href), 32'(tbl[i].hr));
            chk($sformatf("%s_data[%0d]", tag, i), 32'(data), 32'(tbl[i].d));
            chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("%s_done[%0d]", tag, i), 32'(done), 32'(tbl[i].fd));
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic chk_addr(input string tag);
        chk({tag, "_addr_runs"}, 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < addr_q.size() && i < 4; i++)
            chk($sformatf("%s_addr[%0d]", tag, i), 32'(addr_q[i]), 32'(i));
    endtask

    // Runs ncyc cycles from a START-high cycle 0, logging VSYNC rises and FRAME_DONE cycles.
    int rise_q[$];
    int done_q[$];
    task automatic run_log(input int ncyc, input int drop_at, input int p1, input int p2);
        logic prev_vs;
        prev_vs = 1'b0;
        rise_q.delete();
        done_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            start = (c < drop_at) || (c == p1) || (c == p2);
            @(negedge clk);
            if (vsync && !prev_vs) rise_q.push_back(c);
            if (done) done_q.push_back(c);
            prev_vs = vsync;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    logic [7:0] l1[8];
    logic [7:0] l2[8];
    int   first_vs, hr_pulses, hr_len, bad_len;
    logic prev_hr, got;
    logic [15:0] max_a;

    initial begin
        rst = 1'b1; start = 1'b0; start_d = 1'b0;

        l1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12, 8'h23, 8'h34, 8'h45};
        l2 = '{8'h13, 8'h24, 8'h35, 8'h46, 8'h14, 8'h25, 8'h36, 8'h47};
        for (int i = 0; i < 29; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[0].start = 1'b1;
        for (int i = 1; i <= 3; i++) tbl[i].vs = 1'b1;
        for (int i = 1; i <= 27; i++) tbl[i].bz = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl[6 + i].hr  = 1'b1;  tbl[6 + i].d  = l1[i];
            tbl[16 + i].hr = 1'b1;  tbl[16 + i].d = l2[i];
        end
        tbl[27].fd = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame, cycle by cycle; FRAME_DONE lands on the 27th frame cycle.
        addr_q.delete();
        run_table("basic");
        chk_addr("basic");

        // START held: two back-to-back frames, one IDLE cycle between them.
        run_log(62, 56, -1, -1);
        chk("held_vs_rises", 32'(rise_q.size()), 32'd2);
        chk("held_dones", 32'(done_q.size()), 32'd2);
        if (rise_q.size() >= 2 && done_q.size() >= 1) begin
            chk("held_first_done", 32'(done_q[0] - rise_q[0]), 32'd26);
            chk("held_gap", 32'(rise_q[1] - done_q[0]), 32'd2);
        end else begin
            chk("held_sequence_present", 32'(rise_q.size()), 32'd2);
        end
        chk("held_busy_end", 32'(busy), 32'd0);

        // START pulses during LINE and in the FRAME_DONE cycle are ignored.
        run_log(41, 1, 10, 27);
        chk("mid_vs_rises", 32'(rise_q.size()), 32'd1);
        chk("mid_dones", 32'(done_q.size()), 32'd1);
        if (done_q.size() >= 1) chk("mid_done_cycle", 32'(done_q[0]), 32'd27);
        chk("mid_busy_end", 32'(busy), 32'd0);

        // Reset in line 2, byte 5: outputs clear without a clock edge.
        run_log(20, 1, -1, -1);
        chk("pre_rst_href", 32'(href), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vsync", 32'(vsync), 32'd0);
        chk("arst_href", 32'(href), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_data", 32'(data), 32'd0);
        chk("arst_raddr", 32'(raddr), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle_busy%0d", i), 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        addr_q.delete();
        run_table("after_rst");
        chk_addr("after_rst");

        // Default parameters: one full frame.
        first_vs = -1; hr_pulses = 0; hr_len = 0; bad_len = 0;
        prev_hr = 1'b0; got = 1'b0; max_a = 16'h0000;
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        for (int c = 0; c < 40000 && !got; c++) begin
            @(negedge clk);
            if (vsync_d && first_vs < 0) first_vs = c;
            if (href_d) begin
                hr_len++;
            end else if (prev_hr) begin
                hr_pulses++;
                if (hr_len != 320) bad_len++;
                hr_len = 0;
            end
            prev_hr = href_d;
            if (raddr_d > max_a) max_a = raddr_d;
            if (done_d) begin
                got = 1'b1;
                chk("def_frame_len", 32'(c - first_vs + 1), 32'd39392);
            end
            @(posedge clk); #1;
        end
        chk("def_done_seen", 32'(got), 32'd1);
        chk("def_href_pulses", 32'(hr_pulses), 32'd120);
        chk("def_bad_href_len", 32'(bad_len), 32'd0);
        chk("def_last_addr", 32'(max_a), 32'd9599);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
